// File: rtl/axis_mt19937_pkg.sv
// Shared constants, state encoding and twist helper for the AXI-Stream MT19937 generator.
package axis_mt19937_pkg;

  localparam int unsigned N     = 624;
  localparam int unsigned M     = 397;
  localparam int unsigned IDX_W = 10;

  localparam logic [31:0] MATRIX_A   = 32'h9908B0DF;
  localparam logic [31:0] UPPER_MASK = 32'h80000000;
  localparam logic [31:0] LOWER_MASK = 32'h7FFFFFFF;
  localparam logic [31:0] INIT_MULT  = 32'd1812433253;

  localparam logic [31:0] TEMPER_B = 32'h9D2C5680;
  localparam logic [31:0] TEMPER_C = 32'hEFC60000;
  localparam int unsigned TEMPER_U = 11;
  localparam int unsigned TEMPER_S = 7;
  localparam int unsigned TEMPER_T = 15;
  localparam int unsigned TEMPER_L = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN
  } state_t;

  function automatic logic [31:0] mt_twist(input logic [31:0] cur,
                                           input logic [31:0] nxt,
                                           input logic [31:0] mid);
    logic [31:0] y;
    y = (cur & UPPER_MASK) | (nxt & LOWER_MASK);
    return mid ^ (y >> 1) ^ (y[0] ? MATRIX_A : '0);
  endfunction

endpackage

// File: rtl/mt19937_temper.sv
// Combinational MT19937 tempering transform (32-bit word in, tempered word out).
module mt19937_temper
  import axis_mt19937_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  logic [31:0] w_y1;
  logic [31:0] w_y2;
  logic [31:0] w_y3;

  assign w_y1   = i_word ^ (i_word >> TEMPER_U);
  assign w_y2   = w_y1 ^ ((w_y1 << TEMPER_S) & TEMPER_B);
  assign w_y3   = w_y2 ^ ((w_y2 << TEMPER_T) & TEMPER_C);
  assign o_word = w_y3 ^ (w_y3 >> TEMPER_L);

endmodule

// File: rtl/axis_mt19937_pro.sv
// AXI-Stream MT19937 generator: 624-cycle seeding, one tempered word per clock.
// Optional MT19937_TEMPER_PIPE_EN adds one register stage between twist and tempering.
module axis_mt19937_pro
  import axis_mt19937_pkg::*;
#(
  parameter logic [31:0] DEFAULT_SEED = 32'd5489
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed_val,
  input  logic        seed_start,
  output logic [31:0] output_axis_tdata,
  output logic        output_axis_tvalid,
  input  logic        output_axis_tready,
  output logic        busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
  localparam logic [IDX_W-1:0] M_OFF    = IDX_W'(M);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_seed;
  logic [31:0]       r_prev;
  logic [31:0]       r_tdata;
  logic              r_tvalid;
  logic [31:0]       r_mt [N];

  logic [IDX_W-1:0]  w_idx_p1;
  logic [IDX_W-1:0]  w_idx_sum;
  logic [IDX_W-1:0]  w_idx_m;
  logic [31:0]       w_twist;
  logic [31:0]       w_seed_word;
  logic [31:0]       w_temper_in;
  logic [31:0]       w_tempered;
  logic              w_out_free;
  logic              w_gen;
  logic              w_we;
  logic [31:0]       w_wdata;

  assign w_idx_p1  = (r_idx == LAST_IDX) ? '0 : r_idx + ONE_IDX;
  assign w_idx_sum = r_idx + M_OFF;
  assign w_idx_m   = (w_idx_sum >= N_IDX) ? w_idx_sum - N_IDX : w_idx_sum;

  // Twisting one entry per generated word in index order reads exactly the same
  // old/new values as the block-wise reference twist, so the streams match.
  assign w_twist     = mt_twist(r_mt[r_idx], r_mt[w_idx_p1], r_mt[w_idx_m]);
  assign w_seed_word = (r_idx == '0) ? r_seed
                     : INIT_MULT * (r_prev ^ (r_prev >> 30)) + 32'(r_idx);
  assign w_out_free  = !r_tvalid || output_axis_tready;

`ifdef MT19937_TEMPER_PIPE_EN
  logic [31:0] r_pipe_word;
  logic        r_pipe_valid;
  assign w_gen       = (r_state == ST_RUN) && !seed_start && (!r_pipe_valid || w_out_free);
  assign w_temper_in = r_pipe_word;
`else
  assign w_gen       = (r_state == ST_RUN) && !seed_start && w_out_free;
  assign w_temper_in = w_twist;
`endif

  mt19937_temper u_temper (
    .i_word (w_temper_in),
    .o_word (w_tempered)
  );

  always_comb begin
    w_we    = 1'b0;
    w_wdata = w_seed_word;
    if (!seed_start) begin
      if (r_state == ST_SEED) begin
        w_we    = 1'b1;
        w_wdata = w_seed_word;
      end else if (w_gen) begin
        w_we    = 1'b1;
        w_wdata = w_twist;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mt[r_idx] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_seed       <= DEFAULT_SEED;
      r_prev       <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
`ifdef MT19937_TEMPER_PIPE_EN
      r_pipe_word  <= '0;
      r_pipe_valid <= 1'b0;
`endif
    end else if (seed_start) begin
      r_seed       <= seed_val;
      r_state      <= ST_SEED;
      r_idx        <= '0;
      r_tvalid     <= 1'b0;
`ifdef MT19937_TEMPER_PIPE_EN
      r_pipe_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SEED;
          r_idx   <= '0;
        end
        ST_SEED: begin
          r_prev <= w_seed_word;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
          end else begin
            r_idx <= w_idx_p1;
          end
        end
        ST_RUN: begin
`ifdef MT19937_TEMPER_PIPE_EN
          if (w_out_free) begin
            r_tvalid <= r_pipe_valid;
            if (r_pipe_valid) r_tdata <= w_tempered;
          end
          if (w_gen) begin
            r_pipe_word  <= w_twist;
            r_pipe_valid <= 1'b1;
            r_idx        <= w_idx_p1;
          end
`else
          if (w_gen) begin
            r_tdata  <= w_tempered;
            r_tvalid <= 1'b1;
            r_idx    <= w_idx_p1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign output_axis_tdata  = r_tdata;
  assign output_axis_tvalid = r_tvalid;
  assign busy               = (r_state == ST_SEED);

endmodule

// File: tb/tb_axis_mt19937_pro.sv
// Self-checking bench for axis_mt19937_pro against a block-twist MT19937 reference model.
module tb_axis_mt19937_pro;

`ifdef MT19937_TEMPER_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_start;
  logic [31:0] seed_val;
  logic        tready;
  logic        tvalid;
  logic        busy;
  logic [31:0] tdata;

  always #5 clk = ~clk;

  axis_mt19937_pro #(.DEFAULT_SEED(32'd5489)) dut (
    .clk                (clk),
    .rst                (rst),
    .seed_val           (seed_val),
    .seed_start         (seed_start),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tready (tready),
    .busy               (busy)
  );

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] seed;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  // Reference model: classic array-at-a-time generator.
  logic [31:0] m_mt [624];
  int          m_i;
  logic [31:0] exp_q[$];

  function automatic void m_seed(input logic [31:0] s);
    m_mt[0] = s;
    for (int i = 1; i < 624; i++)
      m_mt[i] = 32'd1812433253 * (m_mt[i-1] ^ (m_mt[i-1] >> 30)) + 32'(i);
    m_i = 624;
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] y;
    if (m_i >= 624) begin
      for (int k = 0; k < 624; k++) begin
        y = (m_mt[k] & 32'h80000000) | (m_mt[(k + 1) % 624] & 32'h7FFFFFFF);
        m_mt[k] = m_mt[(k + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
      end
      m_i = 0;
    end
    y = m_mt[m_i];
    m_i++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  function automatic void m_stream(input logic [31:0] s, input int n);
    exp_q.delete();
    m_seed(s);
    for (int k = 0; k < n; k++) exp_q.push_back(m_next());
  endfunction

  // Output monitor: captures accepted words, checks AXI hold and busy/tvalid exclusion.
  logic [31:0] acc_q[$];
  int          mon_bad = 0;
  logic        p_stall = 1'b0;
  logic        p_seed  = 1'b0;
  logic        p_rst   = 1'b0;
  logic [31:0] p_data  = '0;

  always @(negedge clk) begin
    if (rst && tvalid && busy) begin
      mon_bad++;
      $display("FAIL tvalid_busy: tvalid=1 busy=1, required not both");
    end
    if (rst && p_rst && p_stall && !p_seed && (!tvalid || tdata !== p_data)) begin
      mon_bad++;
      $display("FAIL axis_hold: tvalid=%0b tdata=%0d, required tvalid=1 tdata=%0d",
               tvalid, tdata, p_data);
    end
    if (rst && tvalid && tready) acc_q.push_back(tdata);
    p_stall = rst && tvalid && !tready;
    p_data  = tdata;
    p_seed  = seed_start;
    p_rst   = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic seed_run_check(input string nm);
    int guard;
    int cnt;
    int lat;
    guard = 0;
    cnt   = 0;
    lat   = 0;
    @(negedge clk);
    while (!busy && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    while (busy && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check({nm, "_busy_cycles"}, cnt, 624);
    while (!tvalid && lat < 16) begin
      lat++;
      @(negedge clk);
    end
    check({nm, "_first_valid_latency"}, lat, EXP_LAT);
  endtask

  task automatic wait_words(input string nm, input int base, input int n,
                            input bit rnd, input int budget);
    int guard;
    guard = 0;
    while (acc_q.size() < base + n && guard < budget) begin
      tick();
      if (rnd) tready = 1'($urandom_range(0, 1));
      guard++;
    end
    tready = 1'b1;
    check({nm, "_word_count_timeout"}, (acc_q.size() >= base + n), 1'b1);
  endtask

  task automatic compare_run(input string nm, input logic [31:0] s, input int base, input int n);
    int   bad_at;
    logic found;
    m_stream(s, n);
    found  = 1'b0;
    bad_at = 0;
    if (acc_q.size() < base + n) begin
      found  = 1'b1;
      bad_at = acc_q.size() - base;
    end else begin
      for (int k = 0; k < n; k++)
        if (!found && acc_q[base + k] !== exp_q[k]) begin
          found  = 1'b1;
          bad_at = k;
        end
    end
    n_tests++;
    if (found) begin
      n_fail++;
      if (base + bad_at < acc_q.size())
        $display("FAIL %s_stream: word %0d got %0d, required %0d",
                 nm, bad_at, acc_q[base + bad_at], exp_q[bad_at]);
      else
        $display("FAIL %s_stream: only %0d words, required %0d", nm, bad_at, n);
    end
    for (int j = 0; j < vecs.size(); j++)
      if (vecs[j].seed == s && vecs[j].idx < n && base + vecs[j].idx < acc_q.size())
        check($sformatf("%s_vec%0d", nm, vecs[j].idx), acc_q[base + vecs[j].idx], vecs[j].exp);
  endtask

  int base;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    seed_start = 1'b0;
    seed_val   = '0;
    tready     = 1'b0;

    vecs.push_back('{32'd5489, 0, 32'd3499211612});
    vecs.push_back('{32'd5489, 1, 32'd581869302});
    vecs.push_back('{32'd5489, 2, 32'd3890346734});
    m_stream(32'd5489, 1300);
    vecs.push_back('{32'd5489, 623, exp_q[623]});
    vecs.push_back('{32'd5489, 624, exp_q[624]});
    vecs.push_back('{32'd5489, 1299, exp_q[1299]});
    m_stream(32'd19650218, 10000);
    vecs.push_back('{32'd19650218, 0, exp_q[0]});
    vecs.push_back('{32'd19650218, 624, exp_q[624]});
    vecs.push_back('{32'd19650218, 9999, exp_q[9999]});

    repeat (3) tick();
    check("reset_tvalid", tvalid, 1'b0);
    check("reset_tdata", tdata, 32'd0);
    check("reset_busy", busy, 1'b0);

    // seed request while in reset must be ignored
    seed_start = 1'b1;
    seed_val   = 32'hDEADBEEF;
    repeat (2) tick();
    check("reset_seed_ignored_busy", busy, 1'b0);
    seed_start = 1'b0;
    rst        = 1'b1;
    tready     = 1'b1;
    seed_run_check("default");
    base = acc_q.size();
    wait_words("default", base, 1300, 1'b0, 3000);
    compare_run("default", 32'd5489, base, 1300);

    // reseed with the default value mid-stream
    tready     = 1'b0;
    seed_val   = 32'd5489;
    seed_start = 1'b1;
    tick();
    seed_start = 1'b0;
    check("reseed_tvalid_drop", tvalid, 1'b0);
    check("reseed_busy", busy, 1'b1);
    tready = 1'b1;
    seed_run_check("reseed");
    base = acc_q.size();
    wait_words("reseed", base, 700, 1'b0, 2000);
    compare_run("reseed", 32'd5489, base, 700);

    // asynchronous reset mid-stream
    rst = 1'b0;
    #1;
    check("async_rst_stream_tvalid", tvalid, 1'b0);
    check("async_rst_stream_tdata", tdata, 32'd0);
    check("async_rst_stream_busy", busy, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    seed_run_check("rand_ready");
    base = acc_q.size();
    wait_words("rand_ready", base, 1300, 1'b1, 6000);
    compare_run("rand_ready", 32'd5489, base, 1300);

    // asynchronous reset mid-seed
    tready     = 1'b0;
    seed_val   = 32'd777;
    seed_start = 1'b1;
    tick();
    seed_start = 1'b0;
    repeat (100) tick();
    check("mid_seed_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_seed_busy", busy, 1'b0);
    check("async_rst_seed_tvalid", tvalid, 1'b0);
    check("async_rst_seed_tdata", tdata, 32'd0);
    repeat (2) tick();
    rst    = 1'b1;
    tready = 1'b1;
    seed_run_check("after_seed_rst");
    base = acc_q.size();
    wait_words("after_seed_rst", base, 5, 1'b0, 100);
    compare_run("after_seed_rst", 32'd5489, base, 5);

    // seed_start held: only the last sample counts
    tready     = 1'b0;
    seed_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      seed_val = (i == 4) ? 32'd19650218 : $urandom;
      tick();
    end
    seed_start = 1'b0;
    tready     = 1'b1;
    seed_run_check("held_seed");
    base = acc_q.size();
    wait_words("seed19650218", base, 10000, 1'b0, 12000);
    compare_run("seed19650218", 32'd19650218, base, 10000);

    check("protocol_violations", mon_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
